stage3_fu_sequencer: RTL and testbench

//  Generalised start/done sequencer for NUM_FU multi-cycle execute-stage functional units (RV32M, future FP/crypto).

---
 rtl/stage3_types_pkg.sv | 21 ++
 rtl/stage3_fu_sequencer.sv | 123 ++++++++++++
 tb/tb_stage3_fu_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage3_types_pkg.sv
// Shared types and helpers for the stage3 pipeline blocks.
// The FU sequencer uses the state enum and the priority-select helper.
package stage3_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fu_seq_state_t;

    localparam int unsigned LSI_MAX_W = 32;

    // Index of the lowest set bit; 0 when no bit is set (callers qualify with |vec).
    function automatic int unsigned lowest_set_idx(input logic [LSI_MAX_W-1:0] vec);
        lowest_set_idx = 0;
        for (int i = LSI_MAX_W - 1; i >= 0; i--) begin
            if (vec[i]) lowest_set_idx = i;
        end
    endfunction

endpackage

// File: rtl/stage3_fu_sequencer.sv
// Start/done sequencer between the EX stage and its multi-cycle functional units.
// Latches operands, pulses start, waits for done (or watchdog), holds the result across EX/MEM stalls.
module stage3_fu_sequencer
    import stage3_types_pkg::*;
#(
    parameter int NUM_FU      = 2,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NUM_FU-1:0]        fu_sel,
    input  logic                     issue_valid,
    input  logic [DATA_W-1:0]        op_a,
    input  logic [DATA_W-1:0]        op_b,
    input  logic                     ex_flush,
    input  logic                     ex_mem_stall,
    output logic [NUM_FU-1:0]        fu_start,
    output logic [NUM_FU-1:0]        fu_abort,
    output logic [DATA_W-1:0]        fu_op_a,
    output logic [DATA_W-1:0]        fu_op_b,
    input  logic [NUM_FU-1:0]        fu_done,
    input  logic [NUM_FU*DATA_W-1:0] fu_result,
    output logic                     ex_busy,
    output logic [DATA_W-1:0]        result,
    output logic                     result_valid,
    output logic                     fu_timeout,
    output logic [1:0]               dbg_state
);

    localparam int IDW  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNTW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [CNTW-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNTW'(TIMEOUT_CYC - 1) : '0;

    fu_seq_state_t     state;
    logic [IDW-1:0]    id_q;
    logic [IDW-1:0]    sel_id;
    logic [CNTW-1:0]   cnt;
    logic              sel_any;
    logic              accept;
    logic              id_done;
    logic              timeout_hit;
    logic [NUM_FU-1:0] id_onehot;

    // Handshake: an op is taken on a posedge where issue_valid & |fu_sel & !ex_flush
    // while IDLE; ex_busy mirrors that term in IDLE so the producer holds EX until HOLD.
    assign sel_any     = |fu_sel;
    assign sel_id      = IDW'(lowest_set_idx(LSI_MAX_W'(fu_sel)));
    assign accept      = issue_valid & sel_any & ~ex_flush;
    assign id_done     = fu_done[id_q];
    assign id_onehot   = NUM_FU'(1) << id_q;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);
    assign dbg_state   = state;

    always_comb begin
        ex_busy = 1'b0;
        case (state)
            IDLE:    ex_busy = accept;
            RUN:     ex_busy = 1'b1;
            default: ex_busy = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state        <= IDLE;
            id_q         <= '0;
            cnt          <= '0;
            fu_start     <= '0;
            fu_abort     <= '0;
            fu_op_a      <= '0;
            fu_op_b      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            fu_timeout   <= 1'b0;
        end else begin
            fu_start <= '0;
            fu_abort <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        fu_op_a    <= op_a;
                        fu_op_b    <= op_b;
                        id_q       <= sel_id;
                        cnt        <= '0;
                        fu_timeout <= 1'b0;
                        fu_start   <= NUM_FU'(1) << sel_id;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // Flush outranks a coincident done or watchdog expiry.
                    if (ex_flush) begin
                        fu_abort     <= id_onehot;
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end else if (id_done) begin
                        result       <= fu_result[id_q*DATA_W +: DATA_W];
                        result_valid <= 1'b1;
                        state        <= HOLD;
                    end else if (timeout_hit) begin
                        result       <= '0;
                        result_valid <= 1'b1;
                        fu_timeout   <= 1'b1;
                        fu_abort     <= id_onehot;
                        state        <= HOLD;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (ex_flush || !ex_mem_stall) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage3_fu_sequencer.sv
// Directed bench for stage3_fu_sequencer with two emulated FUs and a transaction-level model.
module tb_stage3_fu_sequencer;

  localparam int NUM_FU = 2;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;

  logic                     CLK;
  logic                     nRST;
  logic [NUM_FU-1:0]        fu_sel;
  logic                     issue_valid;
  logic [DATA_W-1:0]        op_a;
  logic [DATA_W-1:0]        op_b;
  logic                     ex_flush;
  logic                     ex_mem_stall;
  logic [NUM_FU-1:0]        fu_start;
  logic [NUM_FU-1:0]        fu_abort;
  logic [DATA_W-1:0]        fu_op_a;
  logic [DATA_W-1:0]        fu_op_b;
  logic [NUM_FU-1:0]        fu_done;
  logic [NUM_FU*DATA_W-1:0] fu_result;
  logic                     ex_busy;
  logic [DATA_W-1:0]        result;
  logic                     result_valid;
  logic                     fu_timeout;
  logic [1:0]               dbg_state;

  int checks   = 0;
  int failures = 0;

  stage3_fu_sequencer #(.NUM_FU(NUM_FU), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .nRST(nRST), .fu_sel(fu_sel), .issue_valid(issue_valid),
    .op_a(op_a), .op_b(op_b), .ex_flush(ex_flush), .ex_mem_stall(ex_mem_stall),
    .fu_start(fu_start), .fu_abort(fu_abort), .fu_op_a(fu_op_a), .fu_op_b(fu_op_b),
    .fu_done(fu_done), .fu_result(fu_result), .ex_busy(ex_busy), .result(result),
    .result_valid(result_valid), .fu_timeout(fu_timeout), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- FU emulators ----------------
  int                fu_lat [NUM_FU];
  logic [DATA_W-1:0] res_val [NUM_FU];
  int                rem [NUM_FU];
  bit                act [NUM_FU];
  int                starts [NUM_FU];
  logic [NUM_FU-1:0] emu_done = '0;
  logic [NUM_FU-1:0] force_done = '0;

  assign fu_done   = emu_done | force_done;
  assign fu_result = {res_val[1], res_val[0]};

  always @(negedge CLK) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (!nRST || fu_abort[i]) begin
        act[i] = 1'b0;
      end else if (fu_start[i]) begin
        act[i] = 1'b1;
        rem[i] = fu_lat[i];
        starts[i]++;
      end else if (act[i]) begin
        if (rem[i] == 0) act[i] = 1'b0;
        else rem[i]--;
      end
      emu_done[i] = act[i] && (rem[i] == 0);
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 executing, 2 result held
  int                m_phase = 0;
  int                m_id = 0;
  int                m_runs = 0;
  logic [DATA_W-1:0] m_result = '0;
  logic [DATA_W-1:0] m_opa = '0;
  logic [DATA_W-1:0] m_opb = '0;
  bit                m_rv = 0;
  bit                m_to = 0;
  logic [NUM_FU-1:0] m_start = '0;
  logic [NUM_FU-1:0] m_abort = '0;
  logic [DATA_W-1:0] exp_q[$];

  function automatic int pick_lowest(input logic [NUM_FU-1:0] sel);
    int id = 0;
    for (int i = NUM_FU - 1; i >= 0; i--) if (sel[i]) id = i;
    return id;
  endfunction

  always @(posedge CLK) begin
    m_start = '0;
    m_abort = '0;
    if (!nRST) begin
      m_phase = 0; m_id = 0; m_runs = 0; m_result = '0;
      m_opa = '0; m_opb = '0; m_rv = 0; m_to = 0;
    end else if (m_phase == 0) begin
      if (issue_valid && (fu_sel != 0) && !ex_flush) begin
        m_id = pick_lowest(fu_sel);
        m_opa = op_a; m_opb = op_b;
        m_to = 0; m_runs = 0;
        m_start[m_id] = 1'b1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (ex_flush) begin
        m_abort[m_id] = 1'b1;
        m_rv = 0;
        m_phase = 0;
      end else if (fu_done[m_id]) begin
        m_result = res_val[m_id];
        m_rv = 1;
        exp_q.push_back(m_result);
        m_phase = 2;
      end else if (m_runs + 1 == TMO) begin
        m_result = '0;
        m_rv = 1;
        m_to = 1;
        m_abort[m_id] = 1'b1;
        exp_q.push_back('0);
        m_phase = 2;
      end else begin
        m_runs++;
      end
    end else begin
      if (ex_flush || !ex_mem_stall) begin
        m_rv = 0;
        m_phase = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;
  bit rv_prev = 0;

  always @(posedge CLK) begin
    bit exp_busy;
    #1;
    if (cmp_en) begin
      exp_busy = (m_phase == 1) ||
                 (m_phase == 0 && issue_valid && (fu_sel != 0) && !ex_flush);
      check("fu_start", 64'(fu_start), 64'(m_start));
      check("fu_abort", 64'(fu_abort), 64'(m_abort));
      check("fu_op_a", 64'(fu_op_a), 64'(m_opa));
      check("fu_op_b", 64'(fu_op_b), 64'(m_opb));
      check("ex_busy", 64'(ex_busy), 64'(exp_busy));
      check("result", 64'(result), 64'(m_result));
      check("result_valid", 64'(result_valid), 64'(m_rv));
      check("fu_timeout", 64'(fu_timeout), 64'(m_to));
      check("state", 64'(dbg_state), 64'(m_phase));
      check("start_abort_excl", 64'(fu_start & fu_abort), 64'(0));
      if (result_valid && !rv_prev) begin
        if (exp_q.size() == 0) check("sb_underflow", 64'(1), 64'(0));
        else check("sb_result", 64'(result), 64'(exp_q.pop_front()));
      end
      rv_prev = result_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    fu_sel = '0; issue_valid = 1'b0; op_a = '0; op_b = '0;
    ex_flush = 1'b0; ex_mem_stall = 1'b0; force_done = '0;
  endtask

  task automatic issue(input logic [NUM_FU-1:0] sel, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b);
    fu_sel = sel; op_a = a; op_b = b; issue_valid = 1'b1;
    @(negedge CLK);
    issue_valid = 1'b0; fu_sel = '0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_lat[i] = 1000; res_val[i] = '0; rem[i] = 0; act[i] = 0; starts[i] = 0;
    end
    idle_inputs();
    nRST = 1'b0;
    @(negedge CLK);
    cmp_en = 1;
    @(negedge CLK);
    check("rst_state", 64'(dbg_state), 64'(0));
    check("rst_result_valid", 64'(result_valid), 64'(0));
    check("rst_fu_op_a", 64'(fu_op_a), 64'(0));
    nRST = 1'b1;
    gap(2);

    // 1: FU0 done 4 cycles after start with 42
    fu_lat[0] = 4; res_val[0] = 32'd42; starts[0] = 0;
    issue(2'b01, 32'd7, 32'd6);
    check("t1_start", 64'(fu_start), 64'h1);
    check("t1_op_a", 64'(fu_op_a), 64'd7);
    check("t1_op_b", 64'(fu_op_b), 64'd6);
    gap(5);
    check("t1_hold_state", 64'(dbg_state), 64'd2);
    check("t1_result", 64'(result), 64'd42);
    check("t1_rv", 64'(result_valid), 64'd1);
    check("t1_busy_hold", 64'(ex_busy), 64'd0);
    check("t1_start_count", 64'(starts[0]), 64'd1);
    gap(3);

    // 2: stall holds the result
    ex_mem_stall = 1'b1;
    issue(2'b01, 32'd7, 32'd6);
    gap(5);
    for (int k = 0; k < 3; k++) begin
      check("t2_hold_state", 64'(dbg_state), 64'd2);
      check("t2_hold_result", 64'(result), 64'd42);
      @(negedge CLK);
    end
    ex_mem_stall = 1'b0;
    @(negedge CLK);
    check("t2_release_state", 64'(dbg_state), 64'd0);
    check("t2_release_rv", 64'(result_valid), 64'd0);
    gap(2);

    // 3: both selected, FU1 done ignored, FU0 wins
    fu_lat[0] = 3; res_val[0] = 32'h1111; res_val[1] = 32'h2222;
    issue(2'b11, 32'd1, 32'd2);
    check("t3_start", 64'(fu_start), 64'h1);
    force_done = 2'b10;
    @(negedge CLK);
    force_done = '0;
    check("t3_ignore_fu1", 64'(dbg_state), 64'd1);
    gap(3);
    check("t3_result", 64'(result), 64'h1111);
    gap(3);

    // 4: flush in 2nd RUN cycle together with done
    fu_lat[0] = 1; res_val[0] = 32'hdead;
    issue(2'b01, 32'd3, 32'd3);
    @(negedge CLK);
    ex_flush = 1'b1;
    @(negedge CLK);
    ex_flush = 1'b0;
    check("t4_abort", 64'(fu_abort), 64'h1);
    check("t4_state", 64'(dbg_state), 64'd0);
    check("t4_rv", 64'(result_valid), 64'd0);
    check("t4_no_capture", 64'(result), 64'h1111);
    gap(2);

    // flush while idle blocks the accept
    fu_sel = 2'b01; issue_valid = 1'b1; ex_flush = 1'b1;
    #1;
    check("idle_flush_busy", 64'(ex_busy), 64'd0);
    @(negedge CLK);
    idle_inputs();
    check("idle_flush_state", 64'(dbg_state), 64'd0);
    gap(1);

    // 1-cycle FU1: start/done in same cycle, HOLD next
    fu_lat[1] = 0; res_val[1] = 32'h99;
    issue(2'b10, 32'd5, 32'd9);
    check("fast_start", 64'(fu_start), 64'h2);
    @(negedge CLK);
    check("fast_state", 64'(dbg_state), 64'd2);
    check("fast_result", 64'(result), 64'h99);
    gap(2);

    // 5: watchdog after TMO RUN cycles
    fu_lat[0] = 1000;
    issue(2'b01, 32'd11, 32'd12);
    gap(TMO);
    check("t5_timeout", 64'(fu_timeout), 64'd1);
    check("t5_result", 64'(result), 64'd0);
    check("t5_abort", 64'(fu_abort), 64'h1);
    check("t5_state", 64'(dbg_state), 64'd2);
    gap(3);

    // 6: reset mid-RUN, then a normal issue
    issue(2'b01, 32'd13, 32'd14);
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    check("t6_rst_state", 64'(dbg_state), 64'd0);
    check("t6_rst_abort", 64'(fu_abort), 64'd0);
    check("t6_rst_op_a", 64'(fu_op_a), 64'd0);
    check("t6_rst_timeout", 64'(fu_timeout), 64'd0);
    nRST = 1'b1;
    @(negedge CLK);
    fu_lat[0] = 2; res_val[0] = 32'h55;
    issue(2'b01, 32'd3, 32'd4);
    gap(3);
    check("t6_result", 64'(result), 64'h55);
    check("t6_rv", 64'(result_valid), 64'd1);
    gap(3);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
